fifo_seq_reader: RTL and testbench
==================================

# fifo_seq_reader

Read-side consumer for the AFIFO read port. It drains words from the FIFO (`r`/`rd`/`rempty`) into a 2-entry output buffer that presents a ready/valid stream downstream. It also checks that popped words form a contiguous incrementing sequence, the same sequence the write-side producer generates. It sits entirely in the FIFO's read-clock domain and is the standard bring-up and streaming endpoint for AFIFO-based paths.

## Interface
Parameters:
- `Width`, 12: data width; must equal the AFIFO `Width`.
- `ErrW`, 16: width of the saturating error counter.
- `CntW`, 32: width of the wrapping word counter.

Ports:
- `clk`  in  1  FIFO read clock (the AFIFO `rclk`).
- `rst_`  in  1  reset, asynchronous, active-low.
- `fifo_r`  out  1  pop strobe; connects to the AFIFO `r`.
- `fifo_rd`  in  Width  FIFO head word; connects to the AFIFO `rd`.
- `fifo_rempty`  in  1  connects to the AFIFO `rempty`.
- `out_valid`  out  1  output word valid.
- `out_data`  out  Width  output word.
- `out_ready`  in  1  downstream accepts.
- `chk_clr`  in  1  synchronous clear of checker state and statistics.
- `seq_err`  out  1  sticky; set on any sequence mismatch.
- `err_count`  out  ErrW  mismatch count, saturating.
- `word_count`  out  CntW  popped-word count, wrapping.
- `bad_exp`, `bad_got`  out  Width  expected and actual values at the first mismatch since reset or clear.

## Operation
- Pop rule: `fifo_r = run & !fifo_rempty & (occ != 2)`.
  - `occ` is the buffer occupancy, 0..2.
  - `run` is a register that is 0 in reset and becomes 1 on the first `clk` edge after `rst_` deasserts.
  - A pop occurs on an edge where `fifo_r` is 1. `fifo_rd` is captured on that same edge.
- Output buffer is a 2-entry skid:
  - `out_data` always comes from the head entry.
  - A transfer occurs when `out_valid & out_ready`.
  - A pop and a transfer in the same cycle leave `occ` unchanged.
  - Words are never dropped or duplicated, and order is preserved.
- Checker FSM is evaluated on every pop:
  - SYNC: the popped word seeds `exp = word+1`. Go to TRACK. No comparison is made.
  - TRACK, `word == exp`: `exp <= word+1`.
  - TRACK, `word != exp`:
    - set `seq_err`;
    - `err_count` += 1, saturating at all-ones;
    - if this is the first mismatch, latch `bad_exp`/`bad_got`;
    - resync with `exp <= word+1`.
- Arithmetic: `exp` is computed modulo 2^Width, so 0xFFF→0x000 is legal for Width=12. `word_count` increments on every pop, modulo 2^CntW.
- `chk_clr` effects:
  - FSM goes to SYNC.
  - `seq_err`, `err_count`, `word_count`, `bad_exp`, `bad_got` are all cleared to 0.
  - The buffer is not affected.
  - If a pop occurs in the same cycle, clear wins. The popped word is still forwarded but is not checked or counted, and the next pop seeds the FSM.

## Timing
- Reset values: `fifo_r`=0, `out_valid`=0, `out_data`=0, `seq_err`=0, `err_count`=0, `word_count`=0, `bad_exp`=0, `bad_got`=0. FSM is in SYNC and `occ`=0.
- Latency: a word popped at edge N is on `out_data` with `out_valid`=1 after edge N (registered).
- Throughput is 1 word/clk when `out_ready` is held high.
- `fifo_r` depends combinationally only on `fifo_rempty` and registered state, never on `out_ready`.
- After `out_ready` falls, at most 2 words are buffered and `fifo_r` drops once `occ`=2.
- Status outputs update on the edge following the pop.
- Reset asserted mid-stream: the buffer is emptied and words already buffered are lost. After reset, the first popped word re-seeds the FSM.

## Structure
- Package `fifo_seq_pkg`:
  - FSM state enum `{SYNC, TRACK}`;
  - default constants for `Width`, `ErrW`, `CntW`.
- One sub-module, `stream_skid2`: the 2-entry ready/valid buffer. It exposes `occ` (or `full`) for the pop rule.
- The checker logic lives in the top module.

## Test plan
- Reset: hold `rst_`=0 with the FIFO non-empty → `fifo_r`=0 and all outputs at their reset values. On the first edge after release `fifo_r` stays 0; it asserts on the next cycle.
- Stream: the FIFO supplies 0x000..0x1FF with `out_ready`=1 → 512 words out in order, `word_count`=512, `err_count`=0, `seq_err`=0.
- Backpressure: `out_ready`=0 for 10 cycles with the FIFO non-empty → exactly 2 pops, then `fifo_r`=0. On release, the sequence continues gap-free.
- Wrap: feed 0xFFE, 0xFFF, 0x000, 0x001 → no error.
- Skip: feed 5, 6, 8, 9, 11 → `err_count`=2, `bad_exp`=7, `bad_got`=8, `seq_err`=1; 9 is accepted after the resync.
- Clear and reset mid-stream:
  - `chk_clr` pulses on a cycle with a pop of 20, then 40, 41 follow → counters are 0 after the clear, 20 is forwarded, 40 seeds the FSM, 41 passes, `word_count`=2.
  - `rst_` asserted with `occ`=2 → `out_valid` drops immediately.

Source files
------------

// File: rtl/fifo_seq_pkg.sv
// Shared constants and checker state type for the AFIFO read-side sequence reader.
package fifo_seq_pkg;

   localparam int unsigned WIDTH_DEF = 12;
   localparam int unsigned ERRW_DEF  = 16;
   localparam int unsigned CNTW_DEF  = 32;

   typedef enum logic {
      SYNC  = 1'b0,
      TRACK = 1'b1
   } chk_state_e;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry ready/valid buffer; head entry always drives out_data.
module stream_skid2
   import fifo_seq_pkg::*;
#(
   parameter int unsigned Width = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             in_valid,
   input  logic [Width-1:0] in_data,
   output logic [1:0]       occ,
   output logic             out_valid,
   output logic [Width-1:0] out_data,
   input  logic             out_ready
);

   logic [Width-1:0] d1;
   logic             xfer;

   assign xfer = out_valid & out_ready;

   // Buffer update: push into the next free slot, shift the tail forward on transfer.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         occ       <= 2'd0;
         out_valid <= 1'b0;
         out_data  <= '0;
         d1        <= '0;
      end else if (in_valid && !xfer) begin
         if (occ == 2'd0) begin
            out_data  <= in_data;
            occ       <= 2'd1;
            out_valid <= 1'b1;
         end else begin
            d1  <= in_data;
            occ <= 2'd2;
         end
      end else if (!in_valid && xfer) begin
         if (occ == 2'd2) begin
            out_data <= d1;
            occ      <= 2'd1;
         end else begin
            occ       <= 2'd0;
            out_valid <= 1'b0;
         end
      end else if (in_valid && xfer) begin
         // Occupancy unchanged: the incoming word replaces whatever leaves.
         if (occ == 2'd1) begin
            out_data <= in_data;
         end else begin
            out_data <= d1;
            d1       <= in_data;
         end
      end
   end

endmodule

// File: rtl/fifo_seq_reader.sv
// AFIFO read-side consumer: drains the FIFO into a skid buffer and checks the word sequence.
module fifo_seq_reader
   import fifo_seq_pkg::*;
#(
   parameter int unsigned Width = WIDTH_DEF,
   parameter int unsigned ErrW  = ERRW_DEF,
   parameter int unsigned CntW  = CNTW_DEF
) (
   input  logic             clk,
   input  logic             rst_,
   output logic             fifo_r,
   input  logic [Width-1:0] fifo_rd,
   input  logic             fifo_rempty,
   output logic             out_valid,
   output logic [Width-1:0] out_data,
   input  logic             out_ready,
   input  logic             chk_clr,
   output logic             seq_err,
   output logic [ErrW-1:0]  err_count,
   output logic [CntW-1:0]  word_count,
   output logic [Width-1:0] bad_exp,
   output logic [Width-1:0] bad_got
);

   logic             run;
   logic [1:0]       occ;
   logic [Width-1:0] exp_word;
   logic [Width-1:0] next_word;
   chk_state_e       state;

   // Pop only from registered state and the FIFO flag, never from out_ready.
   assign fifo_r    = run & ~fifo_rempty & (occ != 2'd2);
   assign next_word = fifo_rd + Width'(1);

   // Hold off popping until one full cycle after reset release.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) run <= 1'b0;
      else       run <= 1'b1;
   end

   stream_skid2 #(.Width(Width)) u_skid (
      .clk       (clk),
      .rst_      (rst_),
      .in_valid  (fifo_r),
      .in_data   (fifo_rd),
      .occ       (occ),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   // Sequence checker FSM and statistics; a clear overrides a coincident pop.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state      <= SYNC;
         exp_word   <= '0;
         seq_err    <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
         bad_exp    <= '0;
         bad_got    <= '0;
      end else if (chk_clr) begin
         state      <= SYNC;
         exp_word   <= '0;
         seq_err    <= 1'b0;
         err_count  <= '0;
         word_count <= '0;
         bad_exp    <= '0;
         bad_got    <= '0;
      end else if (fifo_r) begin
         word_count <= word_count + CntW'(1);
         exp_word   <= next_word;
         case (state)
            SYNC: begin
               state <= TRACK;
            end
            TRACK: begin
               if (fifo_rd != exp_word) begin
                  seq_err <= 1'b1;
                  if (err_count != {ErrW{1'b1}}) err_count <= err_count + ErrW'(1);
                  if (!seq_err) begin
                     bad_exp <= exp_word;
                     bad_got <= fifo_rd;
                  end
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_seq_reader.sv
// Scoreboard bench for fifo_seq_reader with a queue-based FIFO model.
module tb_fifo_seq_reader;

   localparam int unsigned W = 12;

   logic         clk = 1'b0;
   logic         rst_ = 1'b0;
   logic         fifo_r;
   logic [W-1:0] fifo_rd = '0;
   logic         fifo_rempty = 1'b1;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready = 1'b1;
   logic         chk_clr = 1'b0;
   logic         seq_err;
   logic [15:0]  err_count;
   logic [31:0]  word_count;
   logic [W-1:0] bad_exp;
   logic [W-1:0] bad_got;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];
   int           pop_count = 0;
   int           n_vec = 0;
   int           n_bad = 0;

   fifo_seq_reader #(.Width(W), .ErrW(16), .CntW(32)) dut (
      .clk         (clk),
      .rst_        (rst_),
      .fifo_r      (fifo_r),
      .fifo_rd     (fifo_rd),
      .fifo_rempty (fifo_rempty),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .chk_clr     (chk_clr),
      .seq_err     (seq_err),
      .err_count   (err_count),
      .word_count  (word_count),
      .bad_exp     (bad_exp),
      .bad_got     (bad_got)
   );

   always #5 clk = ~clk;

   // FIFO model: pop on the edge the DUT strobes, present the new head at the falling edge.
   always @(posedge clk) begin
      if (fifo_r && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         pop_count = pop_count + 1;
      end
   end

   always @(negedge clk) begin
      fifo_rempty = (fifo_q.size() == 0);
      fifo_rd     = (fifo_q.size() == 0) ? '0 : fifo_q[0];
   end

   // Monitor: every accepted output word must match the scoreboard head.
   always @(negedge clk) begin
      if (rst_ && out_valid && out_ready) begin
         n_vec = n_vec + 1;
         if (exp_q.size() == 0) begin
            n_bad = n_bad + 1;
            $display("FAIL out_data: got %h, scoreboard empty", out_data);
         end else begin
            if (out_data !== exp_q[0]) begin
               n_bad = n_bad + 1;
               $display("FAIL out_data: got %h, want %h", out_data, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec = n_vec + 1;
      if (got !== want) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic push(input logic [W-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) until FIFO and buffer are both empty.
   task automatic wait_drain(input string name, input int max_cyc);
      int n;
      n = 0;
      while ((fifo_q.size() != 0 || out_valid) && n < max_cyc) begin
         step();
         n++;
      end
      check({name, "_drain_timeout"}, 32'(n < max_cyc), 32'd1);
   endtask

   initial begin
      int pc0;
      int n;

      // Reset with a non-empty FIFO
      for (int i = 0; i < 512; i++) push(W'(i));
      repeat (3) step();
      check("rst_fifo_r", 32'(fifo_r), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_seq_err", 32'(seq_err), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_word_count", word_count, 32'd0);
      check("rst_bad_exp", 32'(bad_exp), 32'd0);
      check("rst_bad_got", 32'(bad_got), 32'd0);
      rst_ = 1'b1;
      check("rel_fifo_r_first", 32'(fifo_r), 32'd0);
      step();
      check("rel_fifo_r_next", 32'(fifo_r), 32'd1);

      // Full-rate stream 0x000..0x1FF
      wait_drain("stream", 2000);
      check("stream_word_count", word_count, 32'd512);
      check("stream_err_count", 32'(err_count), 32'd0);
      check("stream_seq_err", 32'(seq_err), 32'd0);

      // Backpressure: exactly two pops then stall
      out_ready = 1'b0;
      pc0 = pop_count;
      for (int i = 512; i < 532; i++) push(W'(i));
      repeat (10) step();
      check("bp_pops", 32'(pop_count - pc0), 32'd2);
      check("bp_fifo_r", 32'(fifo_r), 32'd0);
      out_ready = 1'b1;
      wait_drain("bp", 200);
      check("bp_word_count", word_count, 32'd532);
      check("bp_err_count", 32'(err_count), 32'd0);

      // Wrap 0xFFE..0x001 after a clear
      chk_clr = 1'b1;
      step();
      chk_clr = 1'b0;
      check("clr_word_count", word_count, 32'd0);
      push(12'hFFE); push(12'hFFF); push(12'h000); push(12'h001);
      wait_drain("wrap", 100);
      check("wrap_err_count", 32'(err_count), 32'd0);
      check("wrap_seq_err", 32'(seq_err), 32'd0);
      check("wrap_word_count", word_count, 32'd4);

      // Skips: 5,6,8,9,11
      chk_clr = 1'b1;
      step();
      chk_clr = 1'b0;
      push(12'd5); push(12'd6); push(12'd8); push(12'd9); push(12'd11);
      wait_drain("skip", 100);
      check("skip_err_count", 32'(err_count), 32'd2);
      check("skip_bad_exp", 32'(bad_exp), 32'd7);
      check("skip_bad_got", 32'(bad_got), 32'd8);
      check("skip_seq_err", 32'(seq_err), 32'd1);
      check("skip_word_count", word_count, 32'd5);

      // Clear coincident with the pop of 20
      pc0 = pop_count;
      push(12'd20);
      chk_clr = 1'b1;
      step();
      step();
      chk_clr = 1'b0;
      check("clrpop_popped", 32'(pop_count - pc0), 32'd1);
      check("clrpop_word_count", word_count, 32'd0);
      check("clrpop_err_count", 32'(err_count), 32'd0);
      check("clrpop_seq_err", 32'(seq_err), 32'd0);
      check("clrpop_bad_exp", 32'(bad_exp), 32'd0);
      push(12'd40); push(12'd41);
      wait_drain("clrpop", 100);
      check("seed_word_count", word_count, 32'd2);
      check("seed_err_count", 32'(err_count), 32'd0);
      check("seed_seq_err", 32'(seq_err), 32'd0);

      // Reset with a full buffer: buffered words are lost
      out_ready = 1'b0;
      push(12'd50); push(12'd51); push(12'd52);
      n = 0;
      while (!(out_valid && fifo_q.size() == 1 && !fifo_r) && n < 50) begin
         step();
         n++;
      end
      check("full_wait_timeout", 32'(n < 50), 32'd1);
      #2 rst_ = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_data", 32'(out_data), 32'd0);
      check("midrst_word_count", word_count, 32'd0);
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      step();
      rst_ = 1'b1;
      out_ready = 1'b1;
      push(12'd53);
      wait_drain("midrst", 100);
      check("midrst_after_count", word_count, 32'd2);
      check("midrst_after_err", 32'(err_count), 32'd0);

      repeat (3) step();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
